bound_flasher_ctrl: RTL and testbench



---
 rtl/bound_flasher_ctrl.sv | 88 ++++++++
 tb/tb_bound_flasher_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bound_flasher_ctrl.sv
// Sequencing FSM for the bound flasher: drives the lamp counter's enable/upcount and the lamp bar.
// Define BF_KICKBACK_EN to build the flick kickback transitions in UP2 and UP3.
module bound_flasher_ctrl #(
    parameter int unsigned MAX_LAMPS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flick,
    input  logic [4:0]           cnt,
    output logic                 enable,
    output logic                 upcount,
    output logic [MAX_LAMPS-1:0] lamps,
    output logic                 busy
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StUp1  = 3'd1;
    localparam logic [2:0] StDn1  = 3'd2;
    localparam logic [2:0] StUp2  = 3'd3;
    localparam logic [2:0] StDn2  = 3'd4;
    localparam logic [2:0] StUp3  = 3'd5;
    localparam logic [2:0] StDn3  = 3'd6;

    localparam logic [4:0] CntMax = 5'(MAX_LAMPS);

    logic [2:0] state_q, state_d;
    logic       busy_q, busy_d;
    logic       kick_up2, kick_up3;

`ifdef BF_KICKBACK_EN
    assign kick_up2 = flick && (cnt == 5'd5 || cnt == 5'd10);
    assign kick_up3 = flick && (cnt == 5'd10);
`else
    assign kick_up2 = 1'b0;
    assign kick_up3 = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (flick) state_d = StUp1;
            StUp1:  if (cnt >= 5'd6) state_d = StDn1;
            StDn1:  if (cnt == 5'd0) state_d = StUp2;
            StUp2: begin
                if (kick_up2) state_d = StDn1;
                else if (cnt >= 5'd11) state_d = StDn2;
            end
            StDn2:  if (cnt <= 5'd5) state_d = StUp3;
            StUp3: begin
                if (kick_up3) state_d = StDn2;
                else if (cnt >= CntMax) state_d = StDn3;
            end
            StDn3:  if (cnt == 5'd0) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Reset drops enable in the same cycle it is asserted.
        if (reset) state_d = StIdle;
    end

    // Outputs decode the next state so the counter turns around exactly on a bound.
    always_comb begin
        upcount = (state_d == StUp1) || (state_d == StUp2) || (state_d == StUp3);
        enable  = (state_d != StIdle);
        if (upcount && cnt >= CntMax) enable = 1'b0;
        if (!upcount && cnt == 5'd0) enable = 1'b0;
        busy_d  = (state_d != StIdle);
    end

    always_comb begin
        lamps = '0;
        for (int unsigned i = 0; i < MAX_LAMPS; i++) begin
            lamps[i] = ({27'd0, cnt} > i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_bound_flasher_ctrl.sv
// Bench for bound_flasher_ctrl: attached up/down counter, waypoint-path scoreboard, random flick noise.
`timescale 1ns/1ps
module tb_bound_flasher_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        flick;
    logic [4:0]  cnt;
    logic        enable;
    logic        upcount;
    logic        busy;
    logic [15:0] lamps;
    logic        ld;
    logic [4:0]  ld_val;

    int checks = 0;
    int errors = 0;
    int steps_seen = 0;
    int q_exp[$];
    int wp[$];
    int traj[$];
    bit mon_on = 1'b0;

    logic       en_p = 1'b0;
    logic       up_p = 1'b0;
    logic [4:0] cnt_p = 5'd0;

    always #5 clk = ~clk;

    bound_flasher_ctrl #(.MAX_LAMPS(16)) dut (
        .clk(clk), .reset(reset), .flick(flick), .cnt(cnt),
        .enable(enable), .upcount(upcount), .lamps(lamps), .busy(busy)
    );

    // Lamp up/down counter the controller drives; ld lets the bench force a value.
    always @(posedge clk) begin
        if (reset) cnt <= 5'd0;
        else if (ld) cnt <= ld_val;
        else if (enable) cnt <= upcount ? cnt + 5'd1 : cnt - 5'd1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int therm(input logic [4:0] c);
        if (c >= 5'd16) return 'hFFFF;
        return (1 << c) - 1;
    endfunction

    always @(posedge clk) begin
        en_p  <= mon_on && enable;
        up_p  <= upcount;
        cnt_p <= cnt;
    end

    always @(negedge clk) begin
        int e;
        if (mon_on) begin
            check("lamps", lamps, therm(cnt));
            if (en_p) begin
                steps_seen++;
                if (q_exp.size() == 0) begin
                    check("unexpected_step", cnt, -1);
                end else begin
                    e = q_exp.pop_front();
                    check("cnt_step", cnt, e);
                    check("step_dir", up_p, (e > cnt_p) ? 1 : 0);
                end
            end
        end
    end

    // Expands the waypoint list into the counter value after every step.
    task automatic build_path(input int mode, output int kick_at);
        int cur;
        kick_at = -1;
        wp = {0, 6, 0, 11, 5, 16, 0};
        if (mode == 1) kick_at = 22;
        if (mode == 2) kick_at = 34;
`ifdef BF_KICKBACK_EN
        if (mode == 1) wp = {0, 6, 0, 10, 0, 11, 5, 16, 0};
        if (mode == 2) wp = {0, 6, 0, 11, 5, 10, 5, 16, 0};
`endif
        traj.delete();
        cur = 0;
        foreach (wp[i]) begin
            while (cur != wp[i]) begin
                cur += (wp[i] > cur) ? 1 : -1;
                traj.push_back(cur);
            end
        end
    endtask

    task automatic run_seq(input int mode, input bit hold_end, input bit started);
        int len, kick_at, steps0, c;
        build_path(mode, kick_at);
        len = traj.size();
        if (!started) @(negedge clk);
        flick = 1'b1;
        steps0 = steps_seen;
        foreach (traj[i]) q_exp.push_back(traj[i]);
        #1;
        check("start_busy", busy, 0);
        check("start_enable", enable, 1);
        check("start_upcount", upcount, 1);
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            c = traj[k-1];
            if (k == kick_at) flick = 1'b1;
            else if (k == len) flick = hold_end;
            else flick = (c != 0 && c != 5 && c != 10) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            if (k == 1) check("busy_running", busy, 1);
            if (c == 16) check("lamps_peak", lamps, 'hFFFF);
            if (k == len) check("busy_last_dn3", busy, 1);
        end
        @(negedge clk);
        flick = hold_end;
        #1;
        check("idle_busy", busy, 0);
        check("idle_enable", enable, int'(hold_end));
        check("step_count", steps_seen - steps0, len);
        check("queue_drained", q_exp.size(), 0);
    endtask

    task automatic run_reset_mid();
        int kick_at;
        build_path(0, kick_at);
        foreach (traj[i]) q_exp.push_back(traj[i]);
        @(negedge clk);
        flick = 1'b1;
        for (int k = 1; k <= 37; k++) begin
            @(negedge clk);
            flick = 1'b0;
        end
        reset = 1'b1;
        #1;
        check("mid_cnt", cnt, 13);
        check("mid_rst_enable", enable, 0);
        q_exp.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cnt", cnt, 0);
    endtask

    task automatic run_clamp();
        int stage;
        mon_on = 1'b0;
        q_exp.delete();
        @(negedge clk);
        flick = 1'b1;
        @(negedge clk);
        flick = 1'b0;
        ld = 1'b1;
        ld_val = 5'd16;
        @(negedge clk);
        ld = 1'b0;
        #1;
        check("clamp_cnt", cnt, 16);
        check("clamp_lamps", lamps, 'hFFFF);
        check("clamp_no_up", upcount, 0);
        check("clamp_up_req", int'(enable && upcount), 0);
        @(negedge clk);
        #1;
        check("clamp_no_wrap", cnt, 15);
        stage = 0;
        for (int t = 0; t < 80 && stage < 3; t++) begin
            @(negedge clk);
            #1;
            if (stage == 0 && cnt == 5'd0) stage = 1;
            else if (stage == 1 && cnt == 5'd11) stage = 2;
            else if (stage == 2 && cnt == 5'd10) stage = 3;
        end
        check("clamp_reach_dn2", stage, 3);
        if (stage == 3) begin
            ld = 1'b1;
            ld_val = 5'd0;
            @(negedge clk);
            ld = 1'b0;
            #1;
            check("dn2_zero_cnt", cnt, 0);
            check("dn2_zero_up", upcount, 1);
            check("dn2_zero_en", enable, 1);
            @(negedge clk);
            #1;
            check("dn2_zero_step", cnt, 1);
        end
        for (int t = 0; t < 60 && busy; t++) begin
            @(negedge clk);
            #1;
        end
        check("clamp_end_busy", busy, 0);
        check("clamp_end_cnt", cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        flick = 1'b0;
        ld = 1'b0;
        ld_val = 5'd0;
        repeat (2) begin
            @(negedge clk);
            flick = 1'($urandom_range(0, 1));
            #1;
            check("rst_enable", enable, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        flick = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_enable_after", enable, 0);
        check("rst_lamps", lamps, 0);
        mon_on = 1'b1;

        run_seq(0, 1'b0, 1'b0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        run_seq(1, 1'b0, 1'b0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        run_seq(2, 1'b1, 1'b0);
        run_seq(0, 1'b0, 1'b1);
        @(negedge clk);
        flick = 1'b0;
        run_reset_mid();
        run_seq(0, 1'b0, 1'b0);
        run_clamp();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
